// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-to-serial pattern word feeder, MSB first, with a one-word holding buffer
module pattern_serializer #(
    parameter int WORD_W = 30,
    parameter int LEN_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              stall,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              first_bit,
    output logic              last_bit,
    output logic              err_len
);

    // Words are stored left-aligned so the live bit is always the shifter MSB.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] d,
                                                     input logic [LEN_W-1:0]  n);
        logic [LEN_W:0] sh;
        sh = (LEN_W + 1)'(WORD_W) - {1'b0, n};
        return d << sh;
    endfunction

    logic [WORD_W-1:0] sh_data;
    logic [LEN_W-1:0]  sh_rem;
    logic              sh_first;
    logic [WORD_W-1:0] buf_data;
    logic [LEN_W-1:0]  buf_len;
    logic              buf_valid;

    logic              len_ok;
    logic              accept;
    logic              sh_busy;
    logic              sh_last;
    logic              sh_free;
    logic [WORD_W-1:0] in_aligned;

    assign len_ok     = (in_len != '0) && ({1'b0, in_len} <= (LEN_W + 1)'(WORD_W));
    assign in_ready   = !buf_valid && !flush;
    assign accept     = in_valid && in_ready;
    assign sh_busy    = (sh_rem != '0);
    assign sh_last    = (sh_rem == LEN_W'(1));
    assign sh_free    = !sh_busy || (sh_last && !stall);
    assign in_aligned = align_word(in_data, in_len);

    assign bit_valid = sh_busy && !stall;
    assign bit_out   = sh_data[WORD_W-1];
    assign first_bit = bit_valid && sh_first;
    assign last_bit  = bit_valid && sh_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_data  <= '0;
            sh_rem   <= '0;
            sh_first <= 1'b0;
        end else if (flush) begin
            sh_data  <= '0;
            sh_rem   <= '0;
            sh_first <= 1'b0;
        end else if (sh_free && buf_valid) begin
            sh_data  <= buf_data;
            sh_rem   <= buf_len;
            sh_first <= 1'b1;
        end else if (sh_free && accept && len_ok) begin
            sh_data  <= in_aligned;
            sh_rem   <= in_len;
            sh_first <= 1'b1;
        end else if (sh_free) begin
            // Nothing to follow: go empty but leave sh_data so bit_out keeps its last value.
            sh_rem   <= '0;
            sh_first <= 1'b0;
        end else if (!stall) begin
            sh_data  <= sh_data << 1;
            sh_rem   <= sh_rem - LEN_W'(1);
            sh_first <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data  <= '0;
            buf_len   <= '0;
            buf_valid <= 1'b0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (sh_free && buf_valid) begin
            buf_valid <= 1'b0;
        end else if (accept && len_ok && !sh_free) begin
            buf_data  <= in_aligned;
            buf_len   <= in_len;
            buf_valid <= 1'b1;
        end
    end

    // Illegal-length words are swallowed; only this pulse marks them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_len <= 1'b0;
        end else begin
            err_len <= accept && !len_ok;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - directed and randomized self-checking bench for pattern_serializer
module tb_pattern_serializer;

    localparam int WORD_W = 30;
    localparam int LEN_W  = 5;
    localparam logic [WORD_W-1:0] W2 = 30'b101011110100001011011101011001;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic [LEN_W-1:0]  in_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              stall = 1'b0;
    logic              bit_out;
    logic              bit_valid;
    logic              first_bit;
    logic              last_bit;
    logic              err_len;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } ebit_t;

    pattern_serializer #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .stall     (stall),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered at the drive point of the first bit's cycle; exits at the drive point after the last bit.
    task automatic stream(input logic [WORD_W-1:0] d, input int len, input int stall_at,
                          input int stall_n, input string tag);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    stall = 1'b1;
                    #1;
                    chk({tag, "_stall"}, {bit_valid, bit_out}, {1'b0, d[len-1-i]});
                    next_cycle();
                end
                stall = 1'b0;
            end
            #1;
            chk({tag, "_bit"}, {bit_valid, bit_out, first_bit, last_bit},
                {1'b1, d[len-1-i], (i == 0), (i == len - 1)});
            next_cycle();
        end
    endtask

    task automatic offer(input logic [WORD_W-1:0] d, input logic [LEN_W-1:0] n);
        next_cycle();
        in_valid = 1'b1;
        in_data  = d;
        in_len   = n;
    endtask

    initial begin
        ebit_t       q[$];
        ebit_t       e;
        int          pending;
        int          r;
        logic        err_exp;
        logic        exp_valid;
        logic        exp_ready;
        logic        acc;
        logic        lok;
        logic [7:0]  s3;

        // 1: reset
        repeat (3) next_cycle();
        #1;
        chk("rst_outputs", {bit_out, bit_valid, first_bit, last_bit, err_len}, 5'b0);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_release_outputs", {bit_out, bit_valid, first_bit, last_bit, err_len}, 5'b0);

        // 2: full-width word
        offer(W2, 5'd30);
        #1;
        chk("t2_ready", in_ready, 1'b1);
        chk("t2_idle", bit_valid, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        stream(W2, 30, -1, 0, "t2");
        #1;
        chk("t2_after", bit_valid, 1'b0);

        // 3: back-to-back words through the buffer
        s3 = 8'b10110010;
        offer(30'b1011, 5'd4);
        #1;
        chk("t3_ready_first", in_ready, 1'b1);
        next_cycle();
        in_data = 30'b0010;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                next_cycle();
                in_valid = 1'b0;
            end
            #1;
            chk("t3_bit", {bit_valid, bit_out, first_bit, last_bit},
                {1'b1, s3[7-i], (i == 0 || i == 4), (i == 3 || i == 7)});
            chk("t3_ready", in_ready, !(i >= 1 && i <= 3));
        end
        next_cycle();
        #1;
        chk("t3_after", bit_valid, 1'b0);

        // 4: stall after bit 5
        offer(W2, 5'd30);
        next_cycle();
        in_valid = 1'b0;
        stream(W2, 30, 5, 3, "t4");
        #1;
        chk("t4_after", bit_valid, 1'b0);

        // 5: illegal lengths, then a legal word
        offer(30'h3FFF_FFFF, 5'd0);
        #1;
        chk("t5_ready0", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("t5_err0", {err_len, bit_valid}, 2'b10);
        next_cycle();
        #1;
        chk("t5_err0_clear", {err_len, bit_valid}, 2'b00);
        offer(30'h1234_5678, 5'd31);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("t5_err31", {err_len, bit_valid}, 2'b10);
        next_cycle();
        #1;
        chk("t5_err31_clear", {err_len, bit_valid}, 2'b00);
        offer(30'h2D, 5'd6);
        next_cycle();
        in_valid = 1'b0;
        stream(30'h2D, 6, -1, 0, "t5");
        #1;
        chk("t5_after", {bit_valid, err_len}, 2'b00);

        // 6: flush at bit 10, offered word must be refused
        offer(W2, 5'd30);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t6_pre", {bit_valid, bit_out}, {1'b1, W2[29-i]});
            next_cycle();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 30'h15;
        in_len   = 5'd5;
        #1;
        chk("t6_flush_ready", in_ready, 1'b0);
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_flush_empty", {bit_valid, err_len}, 2'b00);
        next_cycle();
        #1;
        chk("t6_flush_not_taken", bit_valid, 1'b0);
        offer(30'b101, 5'd3);
        next_cycle();
        in_valid = 1'b0;
        stream(30'b101, 3, -1, 0, "t6_new");

        // 6b: reset mid-word
        offer(W2, 5'd30);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6r_pre", bit_valid, 1'b1);
            next_cycle();
        end
        rst = 1'b0;
        #1;
        chk("t6r_async", {bit_out, bit_valid, first_bit, last_bit, err_len}, 5'b0);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("t6r_release", {bit_valid, in_ready}, 2'b01);
        next_cycle();
        #1;
        chk("t6r_abandoned", bit_valid, 1'b0);

        // Randomized traffic against a bit-queue scoreboard
        pending = 0;
        err_exp = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = WORD_W'($urandom);
            r        = int'($urandom_range(0, 19));
            in_len   = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : LEN_W'($urandom_range(1, 30));
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 49) == 0);
            #1;
            exp_ready = !flush && (pending < 2);
            exp_valid = (q.size() != 0) && !stall;
            chk("rnd_ready", in_ready, exp_ready);
            chk("rnd_valid", bit_valid, exp_valid);
            chk("rnd_err", err_len, err_exp);
            if (exp_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_bits", {bit_out, first_bit, last_bit}, {e.b, e.f, e.l});
                if (e.l) pending--;
            end
            acc     = in_valid && exp_ready;
            lok     = (in_len >= 5'd1) && (in_len <= 5'd30);
            err_exp = acc && !lok;
            if (flush) begin
                q.delete();
                pending = 0;
            end else if (acc && lok) begin
                for (int k = int'(in_len) - 1; k >= 0; k--) begin
                    q.push_back('{b: in_data[k], f: (k == int'(in_len) - 1), l: (k == 0)});
                end
                pending++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
